// File: rtl/food_gen.sv
// Food placer: draws LFSR candidates, rejects any that land on the snake, commits a free cell.
// Optional macro FOOD_AVOID_BORDER_EN also rejects candidates on the playfield border.
module food_gen #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [7:0]  MAX_TRIES = 8'd255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   game_state,
  input  logic         get_food,
  input  logic [319:0] snake_x_1dim,
  input  logic [319:0] snake_y_1dim,
  input  logic [5:0]   snake_length,
  output logic [4:0]   food_x,
  output logic [4:0]   food_y,
  output logic         busy
);

  localparam logic [1:0] GS_RUNNING = 2'b00;
  localparam logic [1:0] GS_DIE     = 2'b01;
  localparam logic [1:0] GS_INITIAL = 2'b10;
  localparam logic [4:0] FOOD_X0    = 5'd20;
  localparam logic [4:0] FOOD_Y0    = 5'd9;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, SCAN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [4:0]  draw_x, draw_y;
  logic [4:0]  cand_x, cand_y;
  logic [4:0]  seg_x, seg_y;
  logic [8:0]  seg_base;
  logic [5:0]  idx;
  logic [7:0]  tries;
  logic        gf_prev;
  logic        seg_hit, last_seg;
  logic        ld_cand, commit_draw, commit_scan, idx_inc, try_inc;

  // Rows 24..31 fold back onto 16..23 so every draw is a legal row.
  function automatic logic [4:0] fold_row(input logic [4:0] raw);
    return (raw < 5'd24) ? raw : raw - 5'd8;
  endfunction

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign draw_x   = lfsr[4:0];
  assign draw_y   = fold_row(lfsr[9:5]);
  assign seg_base = 9'(idx) * 9'd5;
  assign seg_x    = snake_x_1dim[seg_base +: 5];
  assign seg_y    = snake_y_1dim[seg_base +: 5];
  assign seg_hit  = (idx < snake_length) && (seg_x == cand_x) && (seg_y == cand_y);
  assign last_seg = (idx >= (snake_length - 6'd1));
  assign busy     = (state != IDLE);

`ifdef FOOD_AVOID_BORDER_EN
  logic on_border;
  assign on_border = (draw_x == 5'd0) || (draw_x == 5'd31) ||
                     (draw_y == 5'd0) || (draw_y == 5'd23);
`endif

  always_comb begin
    state_nxt   = state;
    ld_cand     = 1'b0;
    commit_draw = 1'b0;
    commit_scan = 1'b0;
    idx_inc     = 1'b0;
    try_inc     = 1'b0;
    if (game_state == GS_INITIAL) begin
      state_nxt = IDLE;
    end else if (game_state != GS_DIE) begin
      case (state)
        IDLE: begin
          if ((game_state == GS_RUNNING) && get_food && !gf_prev)
            state_nxt = DRAW;
        end
        DRAW: begin
          if (tries == MAX_TRIES) begin
            commit_draw = 1'b1;
            state_nxt   = IDLE;
          end
`ifdef FOOD_AVOID_BORDER_EN
          else if (on_border) begin
            try_inc = 1'b1;
          end
`endif
          else begin
            ld_cand   = 1'b1;
            state_nxt = SCAN;
          end
        end
        SCAN: begin
          if (snake_length == 6'd0) begin
            commit_scan = 1'b1;
            state_nxt   = IDLE;
          end else if (seg_hit) begin
            try_inc   = 1'b1;
            state_nxt = DRAW;
          end else if (last_seg) begin
            commit_scan = 1'b1;
            state_nxt   = IDLE;
          end else begin
            idx_inc = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= LFSR_SEED;
      state   <= IDLE;
      food_x  <= FOOD_X0;
      food_y  <= FOOD_Y0;
      idx     <= 6'd0;
      tries   <= 8'd0;
      gf_prev <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr_fb};
      state <= state_nxt;
      if (game_state == GS_INITIAL) begin
        food_x  <= FOOD_X0;
        food_y  <= FOOD_Y0;
        idx     <= 6'd0;
        tries   <= 8'd0;
        gf_prev <= 1'b0;
      end else begin
        gf_prev <= get_food;
        if (commit_draw) begin
          food_x <= draw_x;
          food_y <= draw_y;
        end else if (commit_scan) begin
          food_x <= cand_x;
          food_y <= cand_y;
        end
        if (commit_draw || commit_scan)
          tries <= 8'd0;
        else if (try_inc)
          tries <= tries + 8'd1;
        if (ld_cand)
          idx <= 6'd0;
        else if (idx_inc)
          idx <= idx + 6'd1;
      end
    end
  end

  // Candidate register is pure data, only meaningful once DRAW has loaded it.
  always_ff @(posedge clk) begin
    if (ld_cand) begin
      cand_x <= draw_x;
      cand_y <= draw_y;
    end
  end

endmodule
